// File: rtl/lcd_timing_pkg.sv
// Shared types and timing presets for the LCD timing generator.
// The prefetch option is selected with LCD_TIMING_PREFETCH_EN (see lcd_timing_gen).
package lcd_timing_pkg;

  localparam int DEFAULT_CW = 32'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    int h_sync;
    int h_back;
    int h_active;
    int h_front;
    int v_sync;
    int v_back;
    int v_active;
    int v_front;
  } timing_t;

  // 480x272 panel timing, also the generator defaults
  localparam timing_t TIMING_480X272 = '{
    h_sync: 32'd21, h_back: 32'd22, h_active: 32'd480, h_front: 32'd1,
    v_sync: 32'd1,  v_back: 32'd6,  v_active: 32'd272, v_front: 32'd6
  };

  localparam timing_t TIMING_800X480 = '{
    h_sync: 32'd2, h_back: 32'd46, h_active: 32'd800, h_front: 32'd210,
    v_sync: 32'd5, v_back: 32'd23, v_active: 32'd480, v_front: 32'd22
  };

  function automatic int seg_total(input int s, input int b, input int a, input int f);
    return s + b + a + f;
  endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One timing axis: a wrapping position counter with sync/active decode.
// Decodes are combinational from the counter register; the top registers them.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int CW     = DEFAULT_CW,
  parameter int SYNC   = 32'd1,
  parameter int BACK   = 32'd1,
  parameter int ACTIVE = 32'd1,
  parameter int FRONT  = 32'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          sync,
  output logic          active,
  output logic [CW-1:0] pos
);

  localparam int TOTAL = seg_total(SYNC, BACK, ACTIVE, FRONT);

  if (SYNC == 0 || BACK == 0 || ACTIVE == 0 || FRONT == 0 ||
      longint'(TOTAL) > (longint'(1) << CW)) begin : g_bad_cfg
    $error("lcd_axis_counter: zero-length segment or total exceeds counter range");
  end

  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
  localparam logic [CW-1:0] ACT_LO   = CW'(SYNC + BACK);
  localparam logic [CW-1:0] ACT_HI   = CW'(SYNC + BACK + ACTIVE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins, otherwise step and wrap after the last position
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign wrap   = (cnt_q == LAST);
  assign sync   = (cnt_q < SYNC_END);
  assign active = (cnt_q >= ACT_LO) && (cnt_q < ACT_HI);
  assign pos    = active ? (cnt_q - ACT_LO) : '0;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD frame timing generator: IDLE/RUN/DRAIN control over H and V axis counters.
// Define LCD_TIMING_PREFETCH_EN to add the LEAD-cycle-early PREQ/PXPOS/PYPOS outputs.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int CW       = DEFAULT_CW,
  parameter int H_SYNC   = TIMING_480X272.h_sync,
  parameter int H_BACK   = TIMING_480X272.h_back,
  parameter int H_ACTIVE = TIMING_480X272.h_active,
  parameter int H_FRONT  = TIMING_480X272.h_front,
  parameter int V_SYNC   = TIMING_480X272.v_sync,
  parameter int V_BACK   = TIMING_480X272.v_back,
  parameter int V_ACTIVE = TIMING_480X272.v_active,
  parameter int V_FRONT  = TIMING_480X272.v_front,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit DEN_POL   = 1'b1
`ifdef LCD_TIMING_PREFETCH_EN
  ,parameter int LEAD     = 32'd2
`endif
) (
  input  logic          PIXEL_CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DEN,
  output logic [CW-1:0] XPOS,
  output logic [CW-1:0] YPOS,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic          RUNNING
`ifdef LCD_TIMING_PREFETCH_EN
  ,output logic          PREQ
  ,output logic [CW-1:0] PXPOS
  ,output logic [CW-1:0] PYPOS
`endif
);

  localparam logic [CW-1:0] H_ACT_LO = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] V_ACT_LO = CW'(V_SYNC + V_BACK);

  state_e        state_q, state_d;
  logic          run_s, frame_end_s, den_s;
  logic          h_clear_s, h_adv_s, v_adv_s;
  logic [CW-1:0] h_cnt_s, v_cnt_s, h_pos_s, v_pos_s;
  logic          h_wrap_s, v_wrap_s, h_sync_s, v_sync_s, h_active_s, v_active_s;

  logic          hsync_q, vsync_q, den_q, line_start_q, frame_start_q, running_q;
  logic          hsync_d, vsync_d, den_d, line_start_d, frame_start_d, running_d;
  logic [CW-1:0] xpos_q, ypos_q, xpos_d, ypos_d;

  assign run_s       = (state_q != ST_IDLE);
  assign h_clear_s   = ~run_s;
  assign h_adv_s     = run_s;
  assign v_adv_s     = run_s & h_wrap_s;
  assign frame_end_s = h_wrap_s & v_wrap_s;

  lcd_axis_counter #(
    .CW(CW), .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)
  ) u_h_axis (
    .clk(PIXEL_CLK), .rst(RESET), .clear(h_clear_s), .advance(h_adv_s),
    .cnt(h_cnt_s), .wrap(h_wrap_s), .sync(h_sync_s), .active(h_active_s), .pos(h_pos_s)
  );

  lcd_axis_counter #(
    .CW(CW), .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)
  ) u_v_axis (
    .clk(PIXEL_CLK), .rst(RESET), .clear(h_clear_s), .advance(v_adv_s),
    .cnt(v_cnt_s), .wrap(v_wrap_s), .sync(v_sync_s), .active(v_active_s), .pos(v_pos_s)
  );

  // state register
  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: a stop request only takes effect on the frame-end cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN, ST_DRAIN: begin
        if (ENABLE)           state_d = ST_RUN;
        else if (frame_end_s) state_d = ST_IDLE;
        else                  state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // output decode of the current counter state, registered below
  always_comb begin
    den_s         = run_s & h_active_s & v_active_s;
    hsync_d       = (run_s & h_sync_s) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (run_s & v_sync_s) ? VSYNC_POL : ~VSYNC_POL;
    den_d         = den_s ? DEN_POL : ~DEN_POL;
    running_d     = run_s;
    if (den_s) begin
      xpos_d        = h_pos_s;
      ypos_d        = v_pos_s;
      line_start_d  = (h_cnt_s == H_ACT_LO);
      frame_start_d = (h_cnt_s == H_ACT_LO) && (v_cnt_s == V_ACT_LO);
    end else begin
      xpos_d        = '0;
      ypos_d        = '0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // registered outputs
  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      den_q         <= ~DEN_POL;
      xpos_q        <= '0;
      ypos_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      den_q         <= den_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DEN         = den_q;
  assign XPOS        = xpos_q;
  assign YPOS        = ypos_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign RUNNING     = running_q;

`ifdef LCD_TIMING_PREFETCH_EN
  if (LEAD < 1 || LEAD > H_BACK) begin : g_bad_lead
    $error("lcd_timing_gen: LEAD must lie in 1..H_BACK");
  end

  localparam logic [CW:0] PF_LEAD = (CW+1)'(LEAD);
  localparam logic [CW:0] PF_LO   = (CW+1)'(H_SYNC + H_BACK);
  localparam logic [CW:0] PF_HI   = (CW+1)'(H_SYNC + H_BACK + H_ACTIVE);

  logic [CW:0]   la_s;
  logic          pf_act_s;
  logic          preq_q, preq_d;
  logic [CW-1:0] pxpos_q, pxpos_d, pypos_q, pypos_d;

  // LEAD <= H_BACK means a lookahead past the line end is never active,
  // so the prefetch never predicts beyond the current line or frame
  always_comb begin
    la_s     = {1'b0, h_cnt_s} + PF_LEAD;
    pf_act_s = run_s & v_active_s & (la_s >= PF_LO) & (la_s < PF_HI);
    preq_d   = pf_act_s;
    if (pf_act_s) begin
      pxpos_d = la_s[CW-1:0] - H_ACT_LO;
      pypos_d = v_pos_s;
    end else begin
      pxpos_d = '0;
      pypos_d = '0;
    end
  end

  // registered prefetch outputs
  always_ff @(posedge PIXEL_CLK or posedge RESET) begin
    if (RESET) begin
      preq_q  <= 1'b0;
      pxpos_q <= '0;
      pypos_q <= '0;
    end else begin
      preq_q  <= preq_d;
      pxpos_q <= pxpos_d;
      pypos_q <= pypos_d;
    end
  end

  assign PREQ  = preq_q;
  assign PXPOS = pxpos_q;
  assign PYPOS = pypos_q;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen with a small 15x8-clock frame.
// Reference model works on a linear frame index; prefetch checks need LCD_TIMING_PREFETCH_EN.
module tb_lcd_timing_gen;

  localparam int CW = 11;
  localparam int HS = 2, HB = 3, HA = 8, HF = 2;
  localparam int VS = 1, VB = 2, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;   // 15
  localparam int VT = VS + VB + VA + VF;   // 8
  localparam int FT = HT * VT;             // 120

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          den;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
    logic          run;
  } obs_t;

  typedef struct {
    logic en;
    logic hs;
    logic vs;
    logic den;
    logic run;
  } vec_t;

  logic          PIXEL_CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          ENABLE = 1'b0;
  logic          HSYNC, VSYNC, DEN, LINE_START, FRAME_START, RUNNING;
  logic [CW-1:0] XPOS, YPOS;
`ifdef LCD_TIMING_PREFETCH_EN
  logic          PREQ;
  logic [CW-1:0] PXPOS, PYPOS;
`endif

  lcd_timing_gen #(
    .CW(CW), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
`ifdef LCD_TIMING_PREFETCH_EN
    ,.LEAD(2)
`endif
  ) dut (
    .PIXEL_CLK(PIXEL_CLK), .RESET(RESET), .ENABLE(ENABLE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .DEN(DEN), .XPOS(XPOS), .YPOS(YPOS),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START), .RUNNING(RUNNING)
`ifdef LCD_TIMING_PREFETCH_EN
    ,.PREQ(PREQ), .PXPOS(PXPOS), .PYPOS(PYPOS)
`endif
  );

  always #5 PIXEL_CLK = ~PIXEL_CLK;

  obs_t dut_obs;
  assign dut_obs = {HSYNC, VSYNC, DEN, XPOS, YPOS, LINE_START, FRAME_START, RUNNING};

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_mode = 0;        // 0 stopped, 1 running, 2 running with stop pending
  int   m_t = 0;           // linear position inside the frame
  int   den_since_fs = 0;
  int   last_fs_cyc = -1;
  obs_t rec[300];
  int   rec_n = 0;
  bit   rec_on = 1'b0;
`ifdef LCD_TIMING_PREFETCH_EN
  logic [2*CW:0] pf_hist[$];
`endif

  localparam obs_t RESET_OBS = '{hs: 1'b1, vs: 1'b1, den: 1'b0, x: '0, y: '0,
                                 ls: 1'b0, fs: 1'b0, run: 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic obs_t model_out(input int mode, input int t);
    obs_t o;
    int   h, v;
    o = RESET_OBS;
    if (mode != 0) begin
      h = t % HT;
      v = t / HT;
      o.run = 1'b1;
      o.hs  = (h < HS) ? 1'b0 : 1'b1;
      o.vs  = (v < VS) ? 1'b0 : 1'b1;
      if (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) begin
        o.den = 1'b1;
        o.x   = CW'(h - HS - HB);
        o.y   = CW'(v - VS - VB);
        o.ls  = (h == HS + HB);
        o.fs  = (h == HS + HB) && (v == VS + VB);
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_t    = 0;
`ifdef LCD_TIMING_PREFETCH_EN
    pf_hist.delete();
`endif
  endtask

  // one clock: drive ENABLE, advance the model, compare everything after the edge
  task automatic step(input logic en);
    obs_t exp_o;
    bit   fe;
    ENABLE = en;
    @(posedge PIXEL_CLK);
    cyc++;
    exp_o = model_out(m_mode, m_t);
    if (m_mode == 0) begin
      m_t = 0;
      if (en) m_mode = 1;
    end else begin
      fe = (m_t == FT - 1);
      if (en)      m_mode = 1;
      else if (fe) m_mode = 0;
      else         m_mode = 2;
      m_t = fe ? 0 : m_t + 1;
    end
    #1;
    check("outputs_vs_model", dut_obs, exp_o);
    if (FRAME_START === 1'b1) begin
      den_since_fs = 1;
      last_fs_cyc  = cyc;
    end else if (DEN === 1'b1) begin
      den_since_fs++;
    end
    if (rec_on && rec_n < 300) begin
      rec[rec_n] = dut_obs;
      rec_n++;
    end
`ifdef LCD_TIMING_PREFETCH_EN
    check("prefetch_zero_when_idle", PREQ ? 22'd0 : {PXPOS, PYPOS}, 22'd0);
    pf_hist.push_back({PREQ, PXPOS, PYPOS});
    if (pf_hist.size() > 2) begin
      check("prefetch_leads_den_by_2", pf_hist.pop_front(), {DEN, XPOS, YPOS});
    end
`endif
  endtask

  vec_t tbl[6];
  int   n, fs_a, cnt_a, cnt_b, cnt_c, bad, prev, run_len, runs;
  int   starts[$];

  initial begin
    // reset state before any clock edge
    #1 RESET = 1'b1;
    #1;
    check("reset_outputs", dut_obs, RESET_OBS);
`ifdef LCD_TIMING_PREFETCH_EN
    check("reset_preq", {PREQ, PXPOS, PYPOS}, 23'd0);
`endif
    @(posedge PIXEL_CLK);
    @(posedge PIXEL_CLK);
    @(negedge PIXEL_CLK);
    RESET = 1'b0;
    model_reset();

    // start-up vectors: HSYNC/VSYNC assert on the second edge counting the sampling edge
    tbl[0] = '{en: 1'b0, hs: 1'b1, vs: 1'b1, den: 1'b0, run: 1'b0};
    tbl[1] = '{en: 1'b1, hs: 1'b1, vs: 1'b1, den: 1'b0, run: 1'b0};
    tbl[2] = '{en: 1'b1, hs: 1'b0, vs: 1'b0, den: 1'b0, run: 1'b1};
    tbl[3] = '{en: 1'b1, hs: 1'b0, vs: 1'b0, den: 1'b0, run: 1'b1};
    tbl[4] = '{en: 1'b1, hs: 1'b1, vs: 1'b0, den: 1'b0, run: 1'b1};
    tbl[5] = '{en: 1'b0, hs: 1'b1, vs: 1'b0, den: 1'b0, run: 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].en);
      check("tbl_hsync", HSYNC, tbl[i].hs);
      check("tbl_vsync", VSYNC, tbl[i].vs);
      check("tbl_den", DEN, tbl[i].den);
      check("tbl_running", RUNNING, tbl[i].run);
    end
    n = 0;
    while (RUNNING !== 1'b0 && n < 300) begin step(1'b0); n++; end
    check("startup_drain_done", n < 300, 1'b1);

    // steady run from IDLE, recorded for period and count analysis
    rec_on = 1'b1;
    rec_n  = 0;
    for (int i = 0; i < 300; i++) step(1'b1);
    rec_on = 1'b0;
    starts.delete();
    for (int i = 1; i < 300; i++) if (rec[i].hs == 1'b0 && rec[i-1].hs == 1'b1) starts.push_back(i);
    check("hsync_start_count", starts.size(), 20);
    bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != HT) bad++;
    check("hsync_period_15", bad, 0);
    starts.delete();
    for (int i = 1; i < 300; i++) if (rec[i].vs == 1'b0 && rec[i-1].vs == 1'b1) starts.push_back(i);
    check("vsync_start_count", starts.size(), 3);
    bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != FT) bad++;
    check("vsync_period_120", bad, 0);
    starts.delete();
    for (int i = 0; i < 300; i++) if (rec[i].fs) starts.push_back(i);
    check("frame_start_count", starts.size(), 3);
    bad = 0;
    for (int i = 0; i < starts.size(); i++) begin
      if (rec[starts[i]].x != 0 || rec[starts[i]].y != 0 || rec[starts[i]].den != 1'b1) bad++;
      if (i > 0 && starts[i] - starts[i-1] != FT) bad++;
    end
    check("frame_start_align_period", bad, 0);
    if (starts.size() > 0) begin
      fs_a = starts[0];
      cnt_a = 0; cnt_b = 0; cnt_c = 0; bad = 0; prev = 0; run_len = 0; runs = 0;
      for (int i = fs_a; i < fs_a + FT && i < 300; i++) begin
        if (rec[i].fs) cnt_b++;
        if (rec[i].ls) cnt_c++;
        if (rec[i].den) begin
          if (rec[i].x != CW'(run_len) || rec[i].y != CW'(runs)) bad++;
          cnt_a++;
          run_len++;
        end else if (prev) begin
          if (run_len != HA) bad++;
          runs++;
          run_len = 0;
        end
        prev = rec[i].den;
      end
      check("den_cycles_per_frame", cnt_a, 32);
      check("frame_starts_in_window", cnt_b, 1);
      check("line_starts_per_frame", cnt_c, 4);
      check("den_runs_per_frame", runs, 4);
      check("den_run_len_and_coords", bad, 0);
    end

    // stop requested at YPOS=1: the frame still completes all DEN cycles
    n = 0;
    while (!(DEN === 1'b1 && YPOS == CW'(1)) && n < 200) begin step(1'b1); n++; end
    check("reach_ypos1", n < 200, 1'b1);
    n = 0;
    while (RUNNING !== 1'b0 && n < 300) begin step(1'b0); n++; end
    check("running_falls", n < 300, 1'b1);
    check("drained_frame_den_cycles", den_since_fs, 32);
    for (int i = 0; i < 20; i++) step(1'b0);
    check("idle_inactive", dut_obs, RESET_OBS);

    // stop and resume inside one frame: frame period stays 120
    n = 0;
    while (FRAME_START !== 1'b1 && n < 300) begin step(1'b1); n++; end
    check("first_frame_start", n < 300, 1'b1);
    fs_a = cyc;
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    n = 0;
    step(1'b1);
    while (FRAME_START !== 1'b1 && n < 300) begin step(1'b1); n++; end
    check("resume_frame_period", cyc - fs_a, FT);

    // stop sampled exactly on the frame-end cycle of RUN goes straight to IDLE
    n = 0;
    while (!(m_mode == 1 && m_t == FT - 1) && n < 300) begin step(1'b1); n++; end
    check("reach_frame_end", n < 300, 1'b1);
    step(1'b0);
    check("frame_end_last_running", RUNNING, 1'b1);
    step(1'b0);
    check("frame_end_direct_idle", RUNNING, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0);

    // asynchronous reset in the middle of an active line
    n = 0;
    while (DEN !== 1'b1 && n < 300) begin step(1'b1); n++; end
    check("reach_den", n < 300, 1'b1);
    step(1'b1);
    #2 RESET = 1'b1;
    #1;
    check("async_reset_outputs", dut_obs, RESET_OBS);
`ifdef LCD_TIMING_PREFETCH_EN
    check("async_reset_preq", {PREQ, PXPOS, PYPOS}, 23'd0);
`endif
    #2 RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b0);
    check("idle_after_reset", RUNNING, 1'b0);

    // randomized ENABLE bursts with occasional resets, all checked by the model
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, 150);
      ENABLE = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < n; i++) step(ENABLE);
      if ($urandom_range(0, 9) == 0) begin
        #3 RESET = 1'b1;
        #1;
        check("rand_reset_outputs", dut_obs, RESET_OBS);
        #1 RESET = 1'b0;
        model_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
